// File: rtl/boot_packet_uart_tx_if.sv
// Bundle of load, command and serial-line signals for boot_packet_uart_tx.
// Handshake: a payload byte transfers on a rising edge where wr_valid && wr_ready;
// the producer holds wr_valid/wr_data until then, and wr_ready never depends on wr_valid.
interface boot_packet_uart_tx_if;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] count;
   logic       tx;
   logic [2:0] state_dbg;

   modport slave (
      input  wr_valid, wr_data, start,
      output wr_ready, busy, done, count, tx, state_dbg
   );

   modport master (
      output wr_valid, wr_data, start,
      input  wr_ready, busy, done, count, tx, state_dbg
   );
endinterface

// File: rtl/boot_packet_uart_tx.sv
// Boot packet source: buffers payload bytes, accumulates their CRC-32 and, on start,
// sends size byte, CRC-32 (MSB byte first) and payload as 8N1 LSB-first UART frames.
module boot_packet_uart_tx #(
   parameter int CLKS_PER_BIT = 694,
   parameter int MAX_BYTES    = 255,
   parameter int GAP_BITS     = 0
) (
   input logic                   clk,
   input logic                   reset,
   boot_packet_uart_tx_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SIZE = 3'd1,
      S_CRC  = 3'd2,
      S_DATA = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [7:0]      LAST_BIT = 8'(9 + GAP_BITS);
   localparam logic [7:0]      MAX_CNT  = 8'(MAX_BYTES);
   localparam logic [31:0]     POLY     = 32'hEDB88320;
   localparam logic [31:0]     CRC_INIT = 32'hFFFFFFFF;

   // One byte of reflected CRC-32 update.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;        // clocks within the current bit
   logic [7:0]    bit_q, bit_d;        // bit position within the frame incl. gap
   logic [7:0]    byte_q, byte_d;      // byte index within CRC or DATA field
   logic [7:0]    count_q, count_d;
   logic [31:0]   crc_q, crc_d;
   logic          tx_q, tx_d;
   logic          wr_ready_q, wr_ready_d;

   logic [7:0]    pay_mem [256];
   logic          wr_acc;
   logic [7:0]    cur_byte;
   logic [2:0]    bit_sel;
   logic [31:0]   crc_out;

   assign wr_acc  = bus.wr_valid && wr_ready_q;
   assign crc_out = ~crc_q;

   // Payload storage; written only while loading in IDLE.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         pay_mem[count_q] <= bus.wr_data;
      end
   end

   // Next-state, load path, bit timing and next line level.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      count_d  = count_q;
      crc_d    = crc_q;
      cur_byte = 8'd0;
      bit_sel  = 3'd0;
      tx_d     = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (wr_acc) begin
               count_d = count_q + 8'd1;
               crc_d   = crc_step(crc_q, bus.wr_data);
            end
            if (bus.start) begin
               state_d = S_SIZE;
               cnt_d   = '0;
               bit_d   = 8'd0;
               byte_d  = 8'd0;
            end
         end
         S_SIZE, S_CRC, S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (bit_q == LAST_BIT) begin
                  bit_d = 8'd0;
                  case (state_q)
                     S_SIZE: begin
                        state_d = S_CRC;
                        byte_d  = 8'd0;
                     end
                     S_CRC: begin
                        if (byte_q == 8'd3) begin
                           byte_d  = 8'd0;
                           state_d = (count_q == 8'd0) ? S_FIN : S_DATA;
                        end else begin
                           byte_d = byte_q + 8'd1;
                        end
                     end
                     default: begin
                        if (byte_q == count_q - 8'd1) begin
                           state_d = S_FIN;
                        end else begin
                           byte_d = byte_q + 8'd1;
                        end
                     end
                  endcase
               end else begin
                  bit_d = bit_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            count_d = 8'd0;
            crc_d   = CRC_INIT;
         end
         default: state_d = S_IDLE;
      endcase

      // The line level is registered, so it is derived from the position we move to.
      case (state_d)
         S_SIZE: cur_byte = count_d;
         S_CRC: begin
            case (byte_d[1:0])
               2'd0:    cur_byte = crc_out[31:24];
               2'd1:    cur_byte = crc_out[23:16];
               2'd2:    cur_byte = crc_out[15:8];
               default: cur_byte = crc_out[7:0];
            endcase
         end
         S_DATA:  cur_byte = pay_mem[byte_d];
         default: cur_byte = 8'd0;
      endcase

      bit_sel = 3'(bit_d - 8'd1);
      if (state_d == S_SIZE || state_d == S_CRC || state_d == S_DATA) begin
         if (bit_d == 8'd0) begin
            tx_d = 1'b0;
         end else if (bit_d <= 8'd8) begin
            tx_d = cur_byte[bit_sel];
         end else begin
            tx_d = 1'b1;
         end
      end

      wr_ready_d = (state_d == S_IDLE) && (count_d < MAX_CNT);
   end

   // State and datapath registers; reset abandons any packet in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= 8'd0;
         byte_q     <= 8'd0;
         count_q    <= 8'd0;
         crc_q      <= CRC_INIT;
         tx_q       <= 1'b1;
         wr_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         count_q    <= count_d;
         crc_q      <= crc_d;
         tx_q       <= tx_d;
         wr_ready_q <= wr_ready_d;
      end
   end

   assign bus.wr_ready  = wr_ready_q;
   assign bus.busy      = (state_q == S_SIZE) || (state_q == S_CRC) || (state_q == S_DATA);
   assign bus.done      = (state_q == S_FIN);
   assign bus.count     = count_q;
   assign bus.tx        = tx_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_boot_packet_uart_tx.sv
// Bench for boot_packet_uart_tx: loads payloads, triggers packets and compares the
// serial line cycle by cycle against a waveform built from the expected byte list.
module tb_boot_packet_uart_tx;

   localparam int CPB  = 4;
   localparam int GAP  = 1;
   localparam int MAXB = 255;
   localparam int FC   = (10 + GAP) * CPB;   // clocks per frame

   logic clk = 1'b0;
   logic reset = 1'b0;

   boot_packet_uart_tx_if bif();

   boot_packet_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .MAX_BYTES    (MAXB),
      .GAP_BITS     (GAP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   // clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] pay_q[$];   // model of buffered payload
   logic [7:0] exp_q[$];   // expected packet bytes on the line

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Standard CRC-32 computed bit-serially over the whole message.
   function automatic logic [31:0] crc32_ref(input logic [7:0] d[$]);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFFFFFF;
      foreach (d[k]) begin
         for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[k][i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   task automatic build_exp();
      logic [31:0] c;
      c = crc32_ref(pay_q);
      exp_q.delete();
      exp_q.push_back(8'(pay_q.size()));
      exp_q.push_back(c[31:24]);
      exp_q.push_back(c[23:16]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
      foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
   endtask

   // driver: offer one byte for one edge; starts and ends just after a falling edge
   task automatic push_byte(input logic [7:0] b);
      logic acc;
      acc = (pay_q.size() < MAXB);
      bif.wr_valid = 1'b1;
      bif.wr_data  = b;
      check("wr_ready", 32'(bif.wr_ready), 32'(acc));
      @(posedge clk);
      if (acc) pay_q.push_back(b);
      @(negedge clk);
      bif.wr_valid = 1'b0;
   endtask

   // driver + monitor: pulse start and follow the whole packet on tx/busy/done
   task automatic run_packet(input bit collide, input logic [7:0] cb, input int poke_at,
                             input int abort_at, input bit const_exp);
      int         d, wave_bad, busy_bad, frame, bi;
      logic [7:0] by;
      logic       exp_tx, acc;
      wave_bad = 0;
      busy_bad = 0;
      acc = (pay_q.size() < MAXB);
      bif.start = 1'b1;
      if (collide) begin
         bif.wr_valid = 1'b1;
         bif.wr_data  = cb;
         check("collide_ready", 32'(bif.wr_ready), 32'(acc));
      end
      @(posedge clk);
      if (collide && acc) pay_q.push_back(cb);
      if (!const_exp) build_exp();
      @(negedge clk);
      bif.start    = 1'b0;
      bif.wr_valid = 1'b0;
      d = exp_q.size() * FC;
      for (int c = 0; c < d; c++) begin
         if (c == abort_at) begin
            reset = 1'b0;
            #1;
            check("abort_tx", 32'(bif.tx), 32'd1);
            check("abort_busy", 32'(bif.busy), 32'd0);
            check("abort_count", 32'(bif.count), 32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            check("abort_count_rel", 32'(bif.count), 32'd0);
            check("abort_tx_rel", 32'(bif.tx), 32'd1);
            pay_q.delete();
            exp_q.delete();
            return;
         end
         frame = c / FC;
         bi    = (c % FC) / CPB;
         by    = exp_q[frame];
         if (bi == 0)       exp_tx = 1'b0;
         else if (bi <= 8)  exp_tx = by[bi-1];
         else               exp_tx = 1'b1;
         if (bif.tx !== exp_tx) wave_bad++;
         if (bif.busy !== 1'b1 || bif.done !== 1'b0) busy_bad++;
         if (c == poke_at) begin
            bif.start    = 1'b1;
            bif.wr_valid = 1'b1;
            bif.wr_data  = 8'hA5;
            check("busy_wr_ready", 32'(bif.wr_ready), 32'd0);
         end
         @(negedge clk);
         bif.start    = 1'b0;
         bif.wr_valid = 1'b0;
      end
      check("wave_mismatches", 32'(wave_bad), 32'd0);
      check("busy_done_during", 32'(busy_bad), 32'd0);
      check("done_at_end", 32'(bif.done), 32'd1);
      check("busy_at_fin", 32'(bif.busy), 32'd0);
      check("tx_at_fin", 32'(bif.tx), 32'd1);
      @(negedge clk);
      check("done_one_cycle", 32'(bif.done), 32'd0);
      check("count_cleared", 32'(bif.count), 32'd0);
      check("ready_after", 32'(bif.wr_ready), 32'd1);
      pay_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int n, bad;
      bif.wr_valid = 1'b0;
      bif.wr_data  = 8'd0;
      bif.start    = 1'b0;

      // reset block
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(bif.tx), 32'd1);
      check("rst_busy", 32'(bif.busy), 32'd0);
      check("rst_done", 32'(bif.done), 32'd0);
      check("rst_count", 32'(bif.count), 32'd0);
      check("rst_ready", 32'(bif.wr_ready), 32'd0);
      check("rst_state", 32'(bif.state_dbg), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bif.wr_ready), 32'd1);

      // eight zero bytes, known CRC
      for (int i = 0; i < 8; i++) push_byte(8'h00);
      check("count_zeros", 32'(bif.count), 32'd8);
      exp_q = '{8'h08, 8'h65, 8'h22, 8'hDF, 8'h69};
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
      run_packet(1'b0, 8'h00, -1, -1, 1'b1);

      // "123456789", check value CBF43926
      for (int i = 0; i < 9; i++) push_byte(8'(8'h31 + i));
      exp_q = '{8'h09, 8'hCB, 8'hF4, 8'h39, 8'h26};
      for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
      run_packet(1'b0, 8'h00, -1, -1, 1'b1);

      // empty packet
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_packet(1'b0, 8'h00, -1, -1, 1'b1);

      // random payloads
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
         check("count_rand", 32'(bif.count), 32'(n));
         run_packet(1'b0, 8'h00, -1, -1, 1'b0);
      end

      // write coincident with start joins the packet as last byte
      for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
      run_packet(1'b1, 8'($urandom_range(0, 255)), -1, -1, 1'b0);

      // start while busy is ignored
      for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
      run_packet(1'b0, 8'h00, 2 * FC + 7, -1, 1'b0);
      bad = 0;
      for (int c = 0; c < 2 * FC; c++) begin
         if (bif.tx !== 1'b1 || bif.busy !== 1'b0) bad++;
         @(negedge clk);
      end
      check("no_second_packet", 32'(bad), 32'd0);

      // buffer full: 256 offers, only 255 kept
      for (int i = 0; i < 256; i++) push_byte(8'($urandom_range(0, 255)));
      check("count_full", 32'(bif.count), 32'd255);
      check("ready_full", 32'(bif.wr_ready), 32'd0);
      run_packet(1'b0, 8'h00, -1, -1, 1'b0);

      // reset in the middle of the CRC field, then a clean packet
      for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
      run_packet(1'b0, 8'h00, -1, 2 * FC + FC / 2, 1'b0);
      for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
      run_packet(1'b0, 8'h00, -1, -1, 1'b0);

      // report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
